axis_wrr_arbiter: RTL and testbench

Packet-boundary weighted round-robin arbiter that drives the select of an AXIS packet mux. It watches per-source request lines and the mux output handshake, and holds a one-hot grant for whole packets. Each source keeps the bus for up to its weight in consecutive packets, then rotation moves on. Sources that stall mid-packet are evicted by a timeout. It replaces the plain round-robin arbiter in front of the mux when per-source bandwidth shares are needed.

---
 rtl/axis_arb_pkg.sv | 28 ++
 rtl/rr_priority_pick.sv | 49 ++++
 rtl/axis_wrr_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axis_wrr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXIS packet arbiter and its consumers.
package axis_arb_pkg;

   // Arbiter FSM encoding.
   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } arb_state_e;

   localparam int unsigned MAX_SOURCES     = 8;
   localparam int unsigned TIMEOUT_COUNT_W = 16;

   // Index width able to hold 0..n.
   function automatic int unsigned idx_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Binary index of a one-hot vector (up to MAX_SOURCES bits); 0 when all-zero.
   function automatic logic [3:0] onehot2binary(input logic [MAX_SOURCES-1:0] onehot);
      logic [3:0] bin;
      bin = '0;
      for (int unsigned i = 0; i < MAX_SOURCES; i++) begin
         if (onehot[i]) bin = bin | 4'(i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority selector: first set bit of req & mask, searching ptr+1, ptr+2, ...
module rr_priority_pick
   import axis_arb_pkg::*;
#(
   parameter int unsigned NUM_SOURCES = 2,
   localparam int unsigned IDXW = idx_width(NUM_SOURCES)
) (
   input  logic [NUM_SOURCES-1:0] req,
   input  logic [NUM_SOURCES-1:0] mask,
   input  logic [IDXW-1:0]        ptr,
   output logic [NUM_SOURCES-1:0] onehot,
   output logic [IDXW-1:0]        idx,
   output logic                   found
);

   logic [NUM_SOURCES-1:0] cand;
   logic [NUM_SOURCES-1:0] rot;
   logic [IDXW:0]          start;
   int unsigned            pos;

   assign cand  = req & mask;
   // ptr < NUM_SOURCES, so start <= NUM_SOURCES and the doubled vector covers the wrap.
   assign start = {1'b0, ptr} + 1'b1;
   assign rot   = NUM_SOURCES'({cand, cand} >> start);

   // Lowest set bit of the rotated candidates, mapped back to a source index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            pos   = 32'(start) + i;
            if (pos >= NUM_SOURCES) pos = pos - NUM_SOURCES;
            idx   = IDXW'(pos);
         end
      end
   end

   // One-hot form of the selected index.
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
         onehot[i] = found && (idx == IDXW'(i));
      end
   end

endmodule

// File: rtl/axis_wrr_arbiter.sv
// Packet-boundary weighted round-robin arbiter driving an AXIS mux select.
module axis_wrr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int unsigned NUM_SOURCES     = 2,
   parameter int unsigned WEIGHT_WIDTH    = 4,
   parameter int unsigned TIMEOUT_CNT_MAX = 128,
   localparam int unsigned IDXW = idx_width(NUM_SOURCES)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_SOURCES-1:0]              req,
   input  logic [NUM_SOURCES*WEIGHT_WIDTH-1:0] weights,
   input  logic                                m_valid,
   input  logic                                m_ready,
   input  logic                                m_last,
   output logic [NUM_SOURCES-1:0]              grant,
   output logic                                grant_valid,
   output logic [IDXW-1:0]                     grant_idx,
   output logic                                timeout,
   output logic [IDXW-1:0]                     timeout_src,
   output logic [TIMEOUT_COUNT_W-1:0]          timeout_count
);

   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CNT_MAX);

   if (NUM_SOURCES == 0 || NUM_SOURCES > MAX_SOURCES) begin : g_bad_num_sources
      $error("axis_wrr_arbiter: NUM_SOURCES must be in 1..8");
   end
   if (TIMEOUT_CNT_MAX < 2) begin : g_bad_timeout
      $error("axis_wrr_arbiter: TIMEOUT_CNT_MAX must be at least 2");
   end

   arb_state_e                 state_q, state_d;
   logic [NUM_SOURCES-1:0]     grant_q, grant_d;
   logic [IDXW-1:0]            grant_idx_q, grant_idx_d;
   logic [IDXW-1:0]            cur_q, cur_d;
   logic [IDXW-1:0]            ptr_q, ptr_d;
   logic [WEIGHT_WIDTH-1:0]    credit_q, credit_d;
   logic                       started_q, started_d;
   logic [TIMER_W-1:0]         timer_q, timer_d;
   logic                       timeout_q, timeout_d;
   logic [IDXW-1:0]            timeout_src_q, timeout_src_d;
   logic [TIMEOUT_COUNT_W-1:0] timeout_count_q, timeout_count_d;

   logic                   beat, pkt_done, req_cur;
   logic [NUM_SOURCES-1:0] pick_mask, pick_onehot;
   logic [IDXW-1:0]        pick_idx;
   logic                   pick_found;
   logic [WEIGHT_WIDTH-1:0] pick_credit;
   logic                   take, do_release;
   logic [MAX_SOURCES-1:0] grant_wide;

   assign beat     = m_valid & m_ready;
   assign pkt_done = beat & m_last;
   // In BUSY grant_q is onehot(cur), so this is req[cur].
   assign req_cur  = |(req & grant_q);
   // IDLE searches everyone; BUSY excludes the current owner.
   assign pick_mask = (state_q == StIdle) ? {NUM_SOURCES{1'b1}} : ~grant_q;

   rr_priority_pick #(
      .NUM_SOURCES (NUM_SOURCES)
   ) u_pick (
      .req    (req),
      .mask   (pick_mask),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   // Turn length for the candidate source; a zero weight still yields one packet.
   always_comb begin
      pick_credit = '0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
         if (pick_idx == IDXW'(i)) pick_credit = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
      if (pick_credit == '0) pick_credit = WEIGHT_WIDTH'(1);
   end

   // Next-state logic: grant, credit, mid-packet tracking and starvation timeout.
   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      cur_d           = cur_q;
      ptr_d           = ptr_q;
      credit_d        = credit_q;
      started_d       = started_q;
      timer_d         = timer_q;
      timeout_d       = 1'b0;
      timeout_src_d   = timeout_src_q;
      timeout_count_d = timeout_count_q;
      take            = 1'b0;
      do_release      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pick_found) take = 1'b1;
         end
         StBusy: begin
            if (pkt_done) begin
               if (credit_q > WEIGHT_WIDTH'(1)) begin
                  credit_d  = credit_q - WEIGHT_WIDTH'(1);
                  started_d = 1'b0;
                  timer_d   = '0;
               end else begin
                  do_release = 1'b1;
               end
            end else if (beat) begin
               started_d = 1'b1;
               timer_d   = '0;
            end else if (!req_cur && !started_q) begin
               do_release = 1'b1;
            end else if (!req_cur) begin
               if (timer_q == TIMER_W'(TIMEOUT_CNT_MAX - 2)) begin
                  timeout_d     = 1'b1;
                  timeout_src_d = cur_q;
                  if (timeout_count_q != {TIMEOUT_COUNT_W{1'b1}}) begin
                     timeout_count_d = timeout_count_q + 1'b1;
                  end
                  state_d   = StIdle;
                  grant_d   = '0;
                  credit_d  = '0;
                  started_d = 1'b0;
                  timer_d   = '0;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end else begin
               timer_d = '0;
            end
         end
      endcase

      // Release with nobody else waiting parks in IDLE for one cycle.
      if (do_release && !pick_found) begin
         state_d   = StIdle;
         grant_d   = '0;
         started_d = 1'b0;
         timer_d   = '0;
      end

      if (take || (do_release && pick_found)) begin
         state_d   = StBusy;
         grant_d   = pick_onehot;
         cur_d     = pick_idx;
         ptr_d     = pick_idx;
         credit_d  = pick_credit;
         started_d = 1'b0;
         timer_d   = '0;
      end
   end

   // Registered binary index tracks the registered one-hot grant.
   always_comb begin
      grant_wide                  = '0;
      grant_wide[NUM_SOURCES-1:0] = grant_d;
      grant_idx_d                 = IDXW'(onehot2binary(grant_wide));
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         grant_q         <= '0;
         grant_idx_q     <= '0;
         cur_q           <= '0;
         ptr_q           <= IDXW'(NUM_SOURCES - 1);
         credit_q        <= '0;
         started_q       <= 1'b0;
         timer_q         <= '0;
         timeout_q       <= 1'b0;
         timeout_src_q   <= '0;
         timeout_count_q <= '0;
      end else begin
         state_q         <= state_d;
         grant_q         <= grant_d;
         grant_idx_q     <= grant_idx_d;
         cur_q           <= cur_d;
         ptr_q           <= ptr_d;
         credit_q        <= credit_d;
         started_q       <= started_d;
         timer_q         <= timer_d;
         timeout_q       <= timeout_d;
         timeout_src_q   <= timeout_src_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign grant         = grant_q;
   assign grant_valid   = |grant_q;
   assign grant_idx     = grant_idx_q;
   assign timeout       = timeout_q;
   assign timeout_src   = timeout_src_q;
   assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// Scoreboard bench for axis_wrr_arbiter against a packet-level reference model.
module tb_axis_wrr_arbiter;

   localparam int N  = 2;
   localparam int WW = 4;
   localparam int TO = 128;
   localparam int IW = $clog2(N + 1);

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*WW-1:0] weights;
   logic            m_valid, m_ready, m_last;
   logic [N-1:0]    grant;
   logic            grant_valid;
   logic [IW-1:0]   grant_idx;
   logic            timeout;
   logic [IW-1:0]   timeout_src;
   logic [15:0]     timeout_count;

   axis_wrr_arbiter #(
      .NUM_SOURCES     (N),
      .WEIGHT_WIDTH    (WW),
      .TIMEOUT_CNT_MAX (TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .weights       (weights),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_last        (m_last),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .grant_idx     (grant_idx),
      .timeout       (timeout),
      .timeout_src   (timeout_src),
      .timeout_count (timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int gnt;
      int idx;
      int tout;
      int tsrc;
      int tcnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compare DUT outputs against the expectation tagged for this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         void'(sb.pop_front());
         n_total++;
         $display("FAIL sb_stale: expectation missed, cycle %0d", cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         mon_e = sb.pop_front();
         check("grant", int'(grant), mon_e.gnt);
         check("grant_valid", int'(grant_valid), int'(mon_e.gnt != 0));
         check("grant_idx", int'(grant_idx), mon_e.idx);
         check("timeout", int'(timeout), mon_e.tout);
         check("timeout_src", int'(timeout_src), mon_e.tsrc);
         check("timeout_count", int'(timeout_count), mon_e.tcnt);
      end
   end

   // ---------------- reference model ----------------
   int m_owner, m_ptr, m_credit, m_starve, m_tsrc, m_tcount;
   bit m_mid, m_tout;

   function automatic bit bit_of(input logic [N-1:0] v, input int i);
      return ((v >> i) & 1) != 0;
   endfunction

   // First requester after 'from' in cyclic order, skipping 'excl'; -1 if none.
   function automatic int scan(input int from, input logic [N-1:0] r, input int excl);
      for (int k = 1; k <= N; k++) begin
         int i = (from + k) % N;
         if (bit_of(r, i) && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic void give(input int n, input logic [N*WW-1:0] w);
      logic [N*WW-1:0] sh;
      int wt;
      sh       = w >> (n * WW);
      wt       = int'(sh[WW-1:0]);
      m_owner  = n;
      m_ptr    = n;
      m_credit = (wt == 0) ? 1 : wt;
      m_mid    = 0;
      m_starve = 0;
   endfunction

   function automatic void release_turn(input logic [N-1:0] r, input logic [N*WW-1:0] w);
      int n = scan(m_ptr, r, m_owner);
      if (n >= 0) give(n, w);
      else begin
         m_owner  = -1;
         m_mid    = 0;
         m_starve = 0;
      end
   endfunction

   function automatic void model_step(input bit rst, input logic [N-1:0] r,
                                      input logic [N*WW-1:0] w, input bit v, input bit rd,
                                      input bit l);
      bit beat = v && rd;
      bit done = beat && l;
      m_tout = 0;
      if (!rst) begin
         m_owner = -1; m_ptr = N - 1; m_credit = 0; m_starve = 0;
         m_mid = 0; m_tsrc = 0; m_tcount = 0;
      end else if (m_owner < 0) begin
         int n = scan(m_ptr, r, -1);
         if (n >= 0) give(n, w);
      end else if (done) begin
         if (m_credit > 1) begin
            m_credit--;
            m_mid = 0;
            m_starve = 0;
         end else release_turn(r, w);
      end else if (beat) begin
         m_mid = 1;
         m_starve = 0;
      end else if (!bit_of(r, m_owner)) begin
         if (!m_mid) release_turn(r, w);
         else begin
            m_starve++;
            if (m_starve >= TO - 1) begin
               m_tout   = 1;
               m_tsrc   = m_owner;
               m_tcount = (m_tcount < 65535) ? m_tcount + 1 : m_tcount;
               m_owner  = -1;
               m_mid    = 0;
               m_starve = 0;
            end
         end
      end else m_starve = 0;
   endfunction

   // ---------------- driver ----------------
   logic            rst_d;
   logic [N-1:0]    req_d;
   logic            rdy_d;
   logic [N*WW-1:0] w_d;
   int              len_min, len_max;
   int              rem[N];
   int              off[N];

   function automatic int draw_len();
      return int'($urandom_range(len_max, len_min));
   endfunction

   // Drive one cycle (called #1 after a rising edge), predict, then advance.
   task automatic step();
      bit   v, l;
      exp_t e;
      v = rst_d && m_owner >= 0 && bit_of(req_d, m_owner);
      l = v && rem[m_owner] == 1;
      rst_n   = rst_d;
      req     = req_d;
      weights = w_d;
      m_ready = rdy_d;
      m_valid = v;
      m_last  = l;
      if (v && rdy_d) begin
         rem[m_owner]--;
         if (rem[m_owner] == 0) rem[m_owner] = draw_len();
      end
      if (!rst_d) for (int i = 0; i < N; i++) rem[i] = draw_len();
      model_step(rst_d, req_d, w_d, v, rdy_d, l);
      if (m_tout) rem[m_tsrc] = draw_len();
      e.cyc  = cyc + 1;
      e.gnt  = (m_owner < 0) ? 0 : (1 << m_owner);
      e.idx  = (m_owner < 0) ? 0 : m_owner;
      e.tout = m_tout;
      e.tsrc = m_tsrc;
      e.tcnt = m_tcount;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int w0, input int w1);
      w_d[WW-1:0]    = WW'(w0);
      w_d[2*WW-1:WW] = WW'(w1);
   endtask

   task automatic do_reset();
      rst_d = 1'b0;
      step();
      step();
      rst_d = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; weights = '0; m_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;
      rst_d = 1'b1; req_d = '0; rdy_d = 1'b1; w_d = '0;
      len_min = 1; len_max = 1;
      m_owner = -1; m_ptr = N - 1; m_credit = 0; m_starve = 0;
      m_mid = 0; m_tout = 0; m_tsrc = 0; m_tcount = 0;
      for (int i = 0; i < N; i++) begin rem[i] = 1; off[i] = 0; end
      @(posedge clk);
      #1;

      // Equal weights, single-beat packets: strict alternation from source 0.
      set_w(1, 1); len_min = 1; len_max = 1; req_d = 2'b11; rdy_d = 1'b1;
      do_reset();
      repeat (20) step();

      // Weights {3,1}, 4-beat packets.
      set_w(3, 1); len_min = 4; len_max = 4; req_d = 2'b11;
      do_reset();
      repeat (80) step();

      // Lone source 1 with weight 0: one bubble between packets.
      set_w(1, 0); len_min = 2; len_max = 2; req_d = 2'b10;
      do_reset();
      repeat (30) step();

      // Source 0 stalls after two beats; source 1 waits.
      set_w(1, 1); len_min = 10; len_max = 10; req_d = 2'b01;
      do_reset();
      repeat (3) step();
      req_d = 2'b10;
      repeat (135) step();
      check("to_count_after_stall", int'(timeout_count), 1);
      check("to_src_after_stall", int'(timeout_src), 0);

      // Backpressure mid-packet is not starvation.
      set_w(1, 1); len_min = 4; len_max = 4; req_d = 2'b01;
      do_reset();
      repeat (2) step();
      rdy_d = 1'b0;
      repeat (500) step();
      check("no_to_under_backpressure", int'(timeout_count), 0);
      check("grant_held_backpressure", int'(grant), 1);
      rdy_d = 1'b1;
      repeat (20) step();

      // Reset in the middle of a packet.
      set_w(2, 2); len_min = 4; len_max = 4; req_d = 2'b11;
      do_reset();
      repeat (6) step();
      rst_d = 1'b0;
      step();
      check("rst_grant", int'(grant), 0);
      check("rst_to_count", int'(timeout_count), 0);
      rst_d = 1'b1; req_d = 2'b00;
      step();
      req_d = 2'b11;
      repeat (10) step();

      // Randomised traffic: dropouts (some long enough to time out), backpressure,
      // weight changes and occasional reset.
      len_min = 1; len_max = 6;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (off[i] > 0) off[i]--;
            else if ($urandom_range(99, 0) < 2) off[i] = int'($urandom_range(200, 1));
            else if ($urandom_range(99, 0) < 8) off[i] = int'($urandom_range(3, 1));
            req_d[i] = (off[i] == 0);
         end
         rdy_d = ($urandom_range(99, 0) < 80);
         if ($urandom_range(99, 0) < 2) w_d = (N*WW)'($urandom);
         rst_d = ($urandom_range(2999, 0) != 0);
         step();
      end

      @(negedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
